iterative_multiplier_ctrl: RTL and testbench

//  Multi-cycle shift-add multiplier sequencer for the ALU's MUL/MULU operations.
//  - Time-shares one WIDTH-bit carry-look-ahead adder over WIDTH iterations instead of an array multiplier.
//  - Accepts operands on a valid/ready handshake and returns a 2*WIDTH-bit product on a second valid/ready handshake.
//  - Sits between the ALU opcode decoder and the ALU result mux.

---
 rtl/iterative_multiplier_ctrl_pkg.sv | 16 +
 rtl/iterative_multiplier_ctrl_if.sv | 26 ++
 rtl/iterative_multiplier_ctrl_mult_datapath.sv | 75 +++++++
 rtl/iterative_multiplier_ctrl.sv | 82 ++++++++
 tb/tb_iterative_multiplier_ctrl.sv | 232 +++++++++++++++++++++++
 5 files changed

// File: rtl/iterative_multiplier_ctrl_pkg.sv
// Shared definitions for the iterative shift-add multiplier: FSM state encoding.
package iterative_multiplier_ctrl_pkg;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_CALC = 2'd1;
  localparam logic [1:0] ST_FIX  = 2'd2;
  localparam logic [1:0] ST_DONE = 2'd3;

  typedef enum logic [1:0] {
    IDLE = ST_IDLE,
    CALC = ST_CALC,
    FIX  = ST_FIX,
    DONE = ST_DONE
  } state_t;

endpackage

// File: rtl/iterative_multiplier_ctrl_if.sv
// Operand and result handshakes of the multiplier, grouped for the ALU decoder/result mux.
interface iterative_multiplier_ctrl_if #(
  parameter int WIDTH = 8
);
  // Both channels: a transfer happens on a rising edge where valid and ready are both 1;
  // the sender holds valid and its payload stable until that edge, ready may toggle freely.
  logic                 start_valid;
  logic                 start_ready;
  logic [WIDTH-1:0]     a;
  logic [WIDTH-1:0]     b;
  logic                 signed_mode;
  logic                 result_valid;
  logic                 result_ready;
  logic [2*WIDTH-1:0]   product;
  logic                 busy;

  modport master (
    output start_valid, a, b, signed_mode, result_ready,
    input  start_ready, result_valid, product, busy
  );

  modport slave (
    input  start_valid, a, b, signed_mode, result_ready,
    output start_ready, result_valid, product, busy
  );
endinterface

// File: rtl/iterative_multiplier_ctrl_mult_datapath.sv
// Datapath for the shift-add multiplier: operand magnitudes, one shared CLA adder,
// the accumulate-and-shift step and the final sign fix-up.
module mult_datapath #(
  parameter int WIDTH = 8
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 load,
  input  logic                 step,
  input  logic                 fix,
  input  logic [WIDTH-1:0]     a,
  input  logic [WIDTH-1:0]     b,
  input  logic                 signed_mode,
  output logic [2*WIDTH-1:0]   product
);

  logic [2*WIDTH-1:0] acc;
  logic [WIDTH-1:0]   mcand;
  logic [WIDTH-1:0]   mplier;
  logic               neg;

  logic [WIDTH-1:0]   addend;
  logic [WIDTH-1:0]   gen;
  logic [WIDTH-1:0]   prop;
  logic [WIDTH-1:0]   sum;
  logic [WIDTH:0]     carry;
  logic               term;

  // The most-negative value maps to 2^(W-1), which still fits in W unsigned bits.
  function automatic logic [WIDTH-1:0] magnitude(input logic [WIDTH-1:0] x, input logic sm);
    return (sm && x[WIDTH-1]) ? (~x + WIDTH'(1)) : x;
  endfunction

  assign addend = mplier[0] ? mcand : '0;
  assign gen    = acc[2*WIDTH-1:WIDTH] & addend;
  assign prop   = acc[2*WIDTH-1:WIDTH] ^ addend;

  // Each carry is the flat OR of generate terms propagated through every higher bit.
  always_comb begin
    carry = '0;
    term  = 1'b0;
    for (int i = 0; i < WIDTH; i++) begin
      for (int j = 0; j <= i; j++) begin
        term = gen[j];
        for (int k = j + 1; k <= i; k++) begin
          term = term & prop[k];
        end
        carry[i+1] = carry[i+1] | term;
      end
    end
  end

  assign sum = prop ^ carry[WIDTH-1:0];

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      acc     <= '0;
      mcand   <= '0;
      mplier  <= '0;
      neg     <= 1'b0;
      product <= '0;
    end else if (load) begin
      acc     <= '0;
      mcand   <= magnitude(a, signed_mode);
      mplier  <= magnitude(b, signed_mode);
      neg     <= signed_mode & (a[WIDTH-1] ^ b[WIDTH-1]);
    end else if (step) begin
      // Carry becomes the new top bit; acc[0] drops into mplier, whose used LSB falls off.
      {acc, mplier} <= {carry[WIDTH], sum, acc[WIDTH-1:0], mplier[WIDTH-1:1]};
    end else if (fix) begin
      product <= neg ? (~acc + (2*WIDTH)'(1)) : acc;
    end
  end

endmodule

// File: rtl/iterative_multiplier_ctrl.sv
// Sequencer for the ALU's MUL/MULU: FSM, iteration counter and both handshakes around
// the shared-adder datapath.
module iterative_multiplier_ctrl
  import iterative_multiplier_ctrl_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                        clk,
  input  logic                        reset,
  iterative_multiplier_ctrl_if.slave  bus,
  output state_t                      state
);

  localparam int CNT_W = $clog2(WIDTH + 1);
  localparam logic [CNT_W-1:0] LAST_ITER = CNT_W'(WIDTH - 1);

  state_t           state_next;
  logic [CNT_W-1:0] cnt;
  logic [CNT_W-1:0] cnt_next;
  logic             load;
  logic             step;
  logic             fix;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      state <= state_next;
      cnt   <= cnt_next;
    end
  end

  always_comb begin
    state_next       = state;
    cnt_next         = cnt;
    load             = 1'b0;
    step             = 1'b0;
    fix              = 1'b0;
    bus.start_ready  = 1'b0;
    bus.result_valid = 1'b0;
    bus.busy         = 1'b1;
    case (state)
      IDLE: begin
        bus.start_ready = 1'b1;
        bus.busy        = 1'b0;
        if (bus.start_valid) begin
          load       = 1'b1;
          cnt_next   = '0;
          state_next = CALC;
        end
      end
      CALC: begin
        step     = 1'b1;
        cnt_next = cnt + CNT_W'(1);
        if (cnt == LAST_ITER) state_next = FIX;
      end
      FIX: begin
        fix        = 1'b1;
        state_next = DONE;
      end
      DONE: begin
        bus.result_valid = 1'b1;
        if (bus.result_ready) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  mult_datapath #(.WIDTH(WIDTH)) u_datapath (
    .clk         (clk),
    .reset       (reset),
    .load        (load),
    .step        (step),
    .fix         (fix),
    .a           (bus.a),
    .b           (bus.b),
    .signed_mode (bus.signed_mode),
    .product     (bus.product)
  );

endmodule

// File: tb/tb_iterative_multiplier_ctrl.sv
// Directed and random checks of the multiplier sequencer at WIDTH=8 and WIDTH=5,
// with expected products queued at issue time and compared on result_valid.
module tb_iterative_multiplier_ctrl;
  import iterative_multiplier_ctrl_pkg::*;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  iterative_multiplier_ctrl_if #(.WIDTH(8)) bus8 ();
  iterative_multiplier_ctrl_if #(.WIDTH(5)) bus5 ();
  state_t state8;
  state_t state5;

  iterative_multiplier_ctrl #(.WIDTH(8)) dut8 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus8),
    .state (state8)
  );

  iterative_multiplier_ctrl #(.WIDTH(5)) dut5 (
    .clk   (clk),
    .reset (reset),
    .bus   (bus5),
    .state (state5)
  );

  int n_tests = 0;
  int n_fail  = 0;
  logic [15:0] exp_q[$];
  logic [9:0]  exp5_q[$];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_tests++;
    assert (obs === expv) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, expv);
    end
  endtask

  // Reference: interpret operands as w-bit signed or unsigned integers, keep 2w bits.
  function automatic logic [31:0] ref_mul(input int w, input logic [15:0] a, input logic [15:0] b,
                                          input bit sm);
    int ia;
    int ib;
    ia = int'(a);
    ib = int'(b);
    if (sm && a[w-1]) ia = ia - (1 << w);
    if (sm && b[w-1]) ib = ib - (1 << w);
    return 32'((ia * ib) & ((1 << (2 * w)) - 1));
  endfunction

  // Called just after a falling edge. hold = cycles of result backpressure;
  // churn keeps start_valid high and scrambles the operand bus after acceptance.
  task automatic op8(input logic [7:0] a8, input logic [7:0] b8, input bit sm, input int hold,
                     input bit churn, input string tag, output int accept_cyc);
    int t;
    int lat;
    logic [31:0] r;
    logic [15:0] expv;
    logic [15:0] held;
    r = ref_mul(8, {8'b0, a8}, {8'b0, b8}, sm);
    exp_q.push_back(r[15:0]);
    bus8.a            = a8;
    bus8.b            = b8;
    bus8.signed_mode  = sm;
    bus8.start_valid  = 1'b1;
    bus8.result_ready = (hold == 0);
    t = 0;
    while (!bus8.start_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_start_ready"}, 32'(bus8.start_ready), 32'd1);
    @(posedge clk);
    accept_cyc = cyc;
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      if (churn) begin
        bus8.a           = 8'($urandom_range(0, 255));
        bus8.b           = 8'($urandom_range(0, 255));
        bus8.signed_mode = 1'($urandom_range(0, 1));
      end else begin
        bus8.start_valid = 1'b0;
      end
      if (lat == 1) begin
        check({tag, "_calc_start_ready"}, 32'(bus8.start_ready), 32'd0);
        check({tag, "_calc_busy"}, 32'(bus8.busy), 32'd1);
      end
    end while (!bus8.result_valid && lat < 40);
    check({tag, "_latency"}, 32'(lat), 32'd10);
    held = bus8.product;
    for (int i = 0; i < hold; i++) begin
      @(negedge clk);
      check({tag, "_hold_product"}, 32'(bus8.product), 32'(held));
      check({tag, "_hold_valid"}, 32'(bus8.result_valid), 32'd1);
      check({tag, "_hold_start_ready"}, 32'(bus8.start_ready), 32'd0);
    end
    bus8.result_ready = 1'b1;
    expv = exp_q.pop_front();
    check({tag, "_product"}, 32'(bus8.product), 32'(expv));
    @(negedge clk);
    check({tag, "_after_start_ready"}, 32'(bus8.start_ready), 32'd1);
    check({tag, "_after_valid"}, 32'(bus8.result_valid), 32'd0);
    check({tag, "_after_state"}, 32'(state8), 32'(ST_IDLE));
    bus8.start_valid  = 1'b0;
    bus8.result_ready = 1'b0;
  endtask

  task automatic op5(input logic [4:0] a5, input logic [4:0] b5, input bit sm, input string tag);
    int t;
    int lat;
    logic [31:0] r;
    logic [9:0] expv;
    r = ref_mul(5, {11'b0, a5}, {11'b0, b5}, sm);
    exp5_q.push_back(r[9:0]);
    bus5.a            = a5;
    bus5.b            = b5;
    bus5.signed_mode  = sm;
    bus5.start_valid  = 1'b1;
    bus5.result_ready = 1'b1;
    t = 0;
    while (!bus5.start_ready && t < 40) begin
      @(negedge clk);
      t++;
    end
    check({tag, "_start_ready"}, 32'(bus5.start_ready), 32'd1);
    @(posedge clk);
    lat = 0;
    do begin
      @(negedge clk);
      lat++;
      bus5.start_valid = 1'b0;
    end while (!bus5.result_valid && lat < 40);
    check({tag, "_latency"}, 32'(lat), 32'd7);
    expv = exp5_q.pop_front();
    check({tag, "_product"}, 32'(bus5.product), 32'(expv));
    @(negedge clk);
    check({tag, "_after_start_ready"}, 32'(bus5.start_ready), 32'd1);
    bus5.result_ready = 1'b0;
  endtask

  initial begin
    int c1;
    int c2;
    logic [7:0] ra;
    logic [7:0] rb;
    logic [4:0] sa;
    logic [4:0] sb;

    // Clock/reset and idle drive
    reset = 1'b1;
    bus8.start_valid = 1'b0; bus8.a = '0; bus8.b = '0; bus8.signed_mode = 1'b0;
    bus8.result_ready = 1'b0;
    bus5.start_valid = 1'b0; bus5.a = '0; bus5.b = '0; bus5.signed_mode = 1'b0;
    bus5.result_ready = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_start_ready", 32'(bus8.start_ready), 32'd1);
    check("rst_result_valid", 32'(bus8.result_valid), 32'd0);
    check("rst_busy", 32'(bus8.busy), 32'd0);
    check("rst_product", 32'(bus8.product), 32'd0);
    check("rst_state", 32'(state8), 32'(ST_IDLE));
    check("rst_product5", 32'(bus5.product), 32'd0);
    reset = 1'b0;
    @(negedge clk);

    // Unsigned max*max with the exact latency
    op8(8'hFF, 8'hFF, 1'b0, 0, 1'b0, "umax", c1);

    // Signed boundaries
    op8(8'h80, 8'h01, 1'b1, 0, 1'b0, "neg128x1", c1);
    op8(8'h80, 8'h80, 1'b1, 0, 1'b0, "neg128sq", c1);
    op8(8'hFB, 8'h00, 1'b1, 0, 1'b0, "neg5x0", c1);
    op8(8'h00, 8'h00, 1'b0, 0, 1'b0, "zero", c1);

    // Result backpressure for 5 cycles
    op8(8'h12, 8'h34, 1'b0, 5, 1'b0, "backpressure", c1);

    // Operand churn during CALC and back-to-back spacing
    op8(8'h9C, 8'h27, 1'b1, 0, 1'b1, "churn1", c1);
    op8(8'hA5, 8'h5A, 1'b0, 0, 1'b1, "churn2", c2);
    check("back_to_back_spacing", 32'(c2 - c1), 32'd11);

    // Asynchronous reset in the middle of CALC
    bus8.a = 8'h55; bus8.b = 8'h33; bus8.signed_mode = 1'b0; bus8.start_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    bus8.start_valid = 1'b0;
    repeat (3) @(negedge clk);
    check("midrst_pre_busy", 32'(bus8.busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    check("midrst_start_ready", 32'(bus8.start_ready), 32'd1);
    check("midrst_busy", 32'(bus8.busy), 32'd0);
    check("midrst_result_valid", 32'(bus8.result_valid), 32'd0);
    check("midrst_product", 32'(bus8.product), 32'd0);
    check("midrst_state", 32'(state8), 32'(ST_IDLE));
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    op8(8'h07, 8'hFD, 1'b1, 0, 1'b0, "after_rst", c1);

    // Narrow instance boundaries
    op5(5'h10, 5'h10, 1'b1, "w5_neg16sq");
    op5(5'h1F, 5'h1F, 1'b0, "w5_umax");
    op5(5'h10, 5'h01, 1'b1, "w5_neg16x1");

    // Random operands against the reference model
    for (int i = 0; i < 1500; i++) begin
      ra = 8'($urandom_range(0, 255));
      rb = 8'($urandom_range(0, 255));
      op8(ra, rb, 1'($urandom_range(0, 1)), 0, 1'b0, "rand8", c1);
    end
    for (int i = 0; i < 1500; i++) begin
      sa = 5'($urandom_range(0, 31));
      sb = 5'($urandom_range(0, 31));
      op5(sa, sb, 1'($urandom_range(0, 1)), "rand5");
    end

    check("queue8_empty", 32'(exp_q.size()), 32'd0);
    check("queue5_empty", 32'(exp5_q.size()), 32'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
